// File: rtl/multicycle_ctrl_pkg.sv
// Shared processor definitions: FSM state codes, datapath mux encodings, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    // FSM state codes; codes 10-15 are illegal and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Instruction classes carried on Op
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Funct field bit positions
    localparam int FUNCT_IMM_BIT  = 5;
    localparam int FUNCT_LOAD_BIT = 0;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // One cycle's worth of datapath enables and selects
    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle of instruction-field inputs and datapath control outputs of the controller.
// Latency: n/a (wires only).
// Backpressure: MemReady is the only stall input; it travels in this bundle.
interface multicycle_ctrl_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       NoWrite;
    logic       MemReady;

    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       InstrRet;
    logic [3:0] State;

    // Datapath / instruction source side
    modport master (
        output Op, Funct, NoWrite, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, InstrRet, State
    );

    // Controller side
    modport slave (
        input  Op, Funct, NoWrite, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, InstrRet, State
    );

endinterface

// File: rtl/multicycle_ctrl_ctrl_out_rom.sv
// State-to-control-word table for the multicycle controller (Moore outputs).
// Latency: purely combinational, zero cycles.
// Backpressure: MemReady gates the FETCH instruction-register/PC enables only.
module ctrl_out_rom
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    // Decode the current state into datapath enables; unlisted fields stay 0
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.next_pc    = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            S_MEMADR: begin
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                // Write strobe stays up for every stalled cycle of the access
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_op = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_w = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: state register, next-state logic, output gating.
// Latency: outputs combinational from State and inputs; 2-5 cycles per instruction.
// Backpressure: MemReady=0 holds FETCH, MEMRD and MEMWR in place.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.slave   bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t ctrl;
    logic       unused_funct;

    // Only the immediate and load bits of Funct steer the sequence
    assign unused_funct = ^bus.Funct[4:1];

    // State register; reset wins over any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from instruction class and memory handshake
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = bus.Funct[FUNCT_IMM_BIT] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.Funct[FUNCT_LOAD_BIT] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTER,
            S_EXECUTEI: state_d = bus.NoWrite ? S_FETCH : S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    ctrl_out_rom u_rom (
        .state     (state_q),
        .mem_ready (bus.MemReady),
        .ctrl      (ctrl)
    );

    // Architectural side effects are suppressed while reset is held;
    // mux selects pass through since they change no state on their own.
    assign bus.IRWrite   = ctrl.ir_write & ~reset;
    assign bus.NextPC    = ctrl.next_pc  & ~reset;
    assign bus.RegW      = ctrl.reg_w    & ~reset;
    assign bus.MemW      = ctrl.mem_w    & ~reset;
    assign bus.Branch    = ctrl.branch   & ~reset;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.AdrSrc    = ctrl.adr_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ResultSrc = ctrl.result_src;

    // Retire pulse: last cycle of any instruction, i.e. leaving a non-FETCH state for FETCH
    assign bus.InstrRet  = (state_q != S_FETCH) && (state_d == S_FETCH) && !reset;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors, queued expectations.
// Latency: expectations are checked in the same cycle the inputs are applied.
// Backpressure: MemReady stalls exercised in FETCH, MEMRD and MEMWR.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected output word:
    // [16:13] State, 12 IRWrite, 11 NextPC, 10 RegW, 9 MemW, 8 Branch,
    // 7 ALUOp, 6 AdrSrc, 5 ALUSrcA, [4:3] ALUSrcB, [2:1] ResultSrc, 0 InstrRet
    logic [16:0] exp_q[$];

    // Hand-written per-state control table with the cycle-specific bits supplied by the vector
    function automatic logic [16:0] exp_word(input logic [3:0] st, input logic irw,
                                             input logic ret, input logic r);
        logic [16:0] w;
        w = '0;
        w[16:13] = st;
        case (st)
            4'd0, 4'd1: begin w[5] = 1'b1; w[4:3] = 2'b10; w[2:1] = 2'b10; end
            4'd2:       begin w[4:3] = 2'b01; end
            4'd3:       begin w[6] = 1'b1; end
            4'd4:       begin w[2:1] = 2'b01; w[10] = 1'b1; end
            4'd5:       begin w[6] = 1'b1; w[9] = 1'b1; end
            4'd6:       begin w[7] = 1'b1; end
            4'd7:       begin w[4:3] = 2'b01; w[7] = 1'b1; end
            4'd8:       begin w[10] = 1'b1; end
            4'd9:       begin w[4:3] = 2'b01; w[2:1] = 2'b10; w[8] = 1'b1; end
            default:    ;
        endcase
        w[12] = irw;
        w[11] = irw;
        w[0]  = ret;
        if (r) begin
            w[12] = 1'b0; w[11] = 1'b0; w[10] = 1'b0;
            w[9]  = 1'b0; w[8]  = 1'b0; w[0]  = 1'b0;
        end
        return w;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected during that cycle
    task automatic vec(input logic r, input logic [1:0] op, input logic [5:0] f,
                       input logic nw, input logic mr,
                       input logic [3:0] st, input logic irw, input logic ret);
        @(posedge clk);
        #1;
        reset        = r;
        bus.Op       = op;
        bus.Funct    = f;
        bus.NoWrite  = nw;
        bus.MemReady = mr;
        exp_q.push_back(exp_word(st, irw, ret, r));
    endtask

    // Monitor: compare live outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] act;
            logic [16:0] exp;
            exp = exp_q.pop_front();
            act = {bus.State, bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch,
                   bus.ALUOp, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                   bus.InstrRet};
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("FAIL vec%0d ctrl_word: got %05h (state %0d) expected %05h (state %0d)",
                         n_vec, act, act[16:13], exp, exp[16:13]);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.Op       = 2'b00;
        bus.Funct    = 6'b000000;
        bus.NoWrite  = 1'b0;
        bus.MemReady = 1'b1;

        // Reset held: FETCH with enables forced off
        vec(1, 2'b00, 6'b000000, 0, 1, 4'd0, 0, 0);
        vec(1, 2'b00, 6'b000000, 0, 1, 4'd0, 0, 0);
        // Fetch stall then fetch
        vec(0, 2'b00, 6'b001000, 0, 0, 4'd0, 0, 0);
        // ADD register: 0,1,6,8
        vec(0, 2'b00, 6'b001000, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b00, 6'b001000, 0, 1, 4'd1, 0, 0);
        vec(0, 2'b00, 6'b001000, 0, 1, 4'd6, 0, 0);
        vec(0, 2'b00, 6'b001000, 0, 1, 4'd8, 0, 1);
        // CMP immediate: 0,1,7
        vec(0, 2'b00, 6'b110101, 1, 1, 4'd0, 1, 0);
        vec(0, 2'b00, 6'b110101, 1, 1, 4'd1, 0, 0);
        vec(0, 2'b00, 6'b110101, 1, 1, 4'd7, 0, 1);
        // LDR with three stall cycles in MEMRD
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd1, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd2, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 0, 4'd3, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 0, 4'd3, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 0, 4'd3, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd3, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd4, 0, 1);
        // STR with two stall cycles in MEMWR
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd1, 0, 0);
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd2, 0, 0);
        vec(0, 2'b01, 6'b000000, 0, 0, 4'd5, 0, 0);
        vec(0, 2'b01, 6'b000000, 0, 0, 4'd5, 0, 0);
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd5, 0, 1);
        // Branch: 0,1,9
        vec(0, 2'b10, 6'b000000, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b10, 6'b000000, 0, 1, 4'd1, 0, 0);
        vec(0, 2'b10, 6'b000000, 0, 1, 4'd9, 0, 1);
        // Undefined: 0,1 retiring from DECODE
        vec(0, 2'b11, 6'b000000, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b11, 6'b000000, 0, 1, 4'd1, 0, 1);
        // Reset for two cycles mid-MEMWR with MemReady low
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd1, 0, 0);
        vec(0, 2'b01, 6'b000000, 0, 1, 4'd2, 0, 0);
        vec(0, 2'b01, 6'b000000, 0, 0, 4'd5, 0, 0);
        vec(1, 2'b01, 6'b000000, 0, 0, 4'd5, 0, 0);
        vec(1, 2'b01, 6'b000000, 0, 0, 4'd0, 0, 0);
        vec(0, 2'b11, 6'b000000, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b11, 6'b000000, 0, 1, 4'd1, 0, 1);
        // Reset mid-MEMRD
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd1, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd2, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 0, 4'd3, 0, 0);
        vec(1, 2'b01, 6'b000001, 0, 0, 4'd3, 0, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd0, 1, 0);
        vec(0, 2'b01, 6'b000001, 0, 1, 4'd1, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
